// File: rtl/reg_writeback_queue_if.sv
// Bundle of the writeback request, register-file write port and bypass lookup
// signals shared between the datapath/controller and reg_writeback_queue.
interface reg_writeback_queue_if #(
  parameter int ADD_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                     wb_valid;
  logic                     wb_ready;
  logic [ADD_WIDTH-1:0]     wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     drain_en;
  logic                     rf_we3;
  logic [ADD_WIDTH-1:0]     rf_a3;
  logic [DATA_WIDTH-1:0]    rf_wd3;
  logic [ADD_WIDTH-1:0]     lk_addr1;
  logic [ADD_WIDTH-1:0]     lk_addr2;
  logic                     lk_hit1;
  logic                     lk_hit2;
  logic [DATA_WIDTH-1:0]    lk_data1;
  logic [DATA_WIDTH-1:0]    lk_data2;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output wb_valid, wb_addr, wb_data, drain_en, lk_addr1, lk_addr2,
    input  wb_ready, rf_we3, rf_a3, rf_wd3, lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, drain_en, lk_addr1, lk_addr2,
    output wb_ready, rf_we3, rf_a3, rf_wd3, lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Writeback FIFO in front of the register-file write port, draining one entry per
// permitted cycle, with youngest-match bypass of queued writes for both read ports.
module reg_writeback_queue #(
  parameter int ADD_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_writeback_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADD_WIDTH-1:0]  addr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0]      valid_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH:0]   lk1_s;
  logic [DATA_WIDTH:0]   lk2_s;

  // Walk from the head towards wr_ptr so the last match found is the youngest.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADD_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] res;
    logic [PW-1:0]       idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_r + PW'(i);
      if ((a != '0) && valid_r[idx] && (addr_mem_r[idx] == a)) begin
        res = {1'b1, data_mem_r[idx]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == '0);
  // Writes to $zero are acknowledged but never stored.
  assign push_s  = bus.wb_valid & ~full_s & (bus.wb_addr != '0);
  assign pop_s   = bus.drain_en & ~empty_s;

  // Write port, handshake and occupancy outputs.
  always_comb begin
    bus.wb_ready = ~full_s;
    bus.rf_we3   = pop_s;
    bus.count    = count_r;
    if (empty_s) begin
      bus.rf_a3  = '0;
      bus.rf_wd3 = '0;
    end else begin
      bus.rf_a3  = addr_mem_r[rd_ptr_r];
      bus.rf_wd3 = data_mem_r[rd_ptr_r];
    end
  end

  // Bypass lookup over queued entries for both read addresses.
  always_comb begin
    lk1_s        = lookup(bus.lk_addr1);
    lk2_s        = lookup(bus.lk_addr2);
    bus.lk_hit1  = lk1_s[DATA_WIDTH];
    bus.lk_data1 = lk1_s[DATA_WIDTH-1:0];
    bus.lk_hit2  = lk2_s[DATA_WIDTH];
    bus.lk_data2 = lk2_s[DATA_WIDTH-1:0];
  end

  // Entry storage, valid bits, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= '0;
        data_mem_r[i] <= '0;
      end
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= bus.wb_addr;
        data_mem_r[wr_ptr_r] <= bus.wb_data;
        valid_r[wr_ptr_r]    <= 1'b1;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      // push and pop never target the same slot: push needs !full, pop needs !empty.
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: vector table plus sequences for reset,
// full/wrap and continuous drain.
module tb_reg_writeback_queue;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DP = 4;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  reg_writeback_queue_if #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  reg_writeback_queue #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          drain;
    logic [AW-1:0] lk1;
    logic [AW-1:0] lk2;
    logic          e_ready;
    logic          e_we;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
    logic          e_hit1;
    logic [DW-1:0] e_d1;
    logic          e_hit2;
    logic [DW-1:0] e_d2;
    logic [2:0]    e_cnt;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(
    input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dr,
    input logic [AW-1:0] l1, input logic [AW-1:0] l2,
    input logic rdy, input logic we, input logic [AW-1:0] a3, input logic [DW-1:0] wd,
    input logic h1, input logic [DW-1:0] d1, input logic h2, input logic [DW-1:0] d2,
    input logic [2:0] c);
    vec_t r;
    r.valid = v;   r.addr = a;    r.data = d;    r.drain = dr;
    r.lk1 = l1;    r.lk2 = l2;    r.e_ready = rdy; r.e_we = we;
    r.e_a3 = a3;   r.e_wd = wd;   r.e_hit1 = h1; r.e_d1 = d1;
    r.e_hit2 = h2; r.e_d2 = d2;   r.e_cnt = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic dr, input logic [AW-1:0] l1, input logic [AW-1:0] l2);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    bus.drain_en = dr;
    bus.lk_addr1 = l1;
    bus.lk_addr2 = l2;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    //            v     addr   data          drn   lk1    lk2    rdy   we    a3     wd          h1    d1          h2    d2          cnt
    vecs[0]  = mk(1'b1, 5'd5,  32'h11,       1'b0, 5'd5,  5'd6,  1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0);
    vecs[1]  = mk(1'b1, 5'd6,  32'h22,       1'b0, 5'd5,  5'd6,  1'b1, 1'b0, 5'd5,  32'h11,     1'b1, 32'h11,     1'b0, 32'h0,      3'd1);
    vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd6,  1'b1, 1'b0, 5'd5,  32'h11,     1'b1, 32'h11,     1'b1, 32'h22,     3'd2);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd6,  1'b1, 1'b1, 5'd5,  32'h11,     1'b1, 32'h11,     1'b1, 32'h22,     3'd2);
    vecs[4]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd6,  1'b1, 1'b1, 5'd6,  32'h22,     1'b0, 32'h0,      1'b1, 32'h22,     3'd1);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd6,  1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0);
    vecs[6]  = mk(1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0);
    vecs[7]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0);
    vecs[8]  = mk(1'b1, 5'd7,  32'h1,        1'b0, 5'd7,  5'd8,  1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0);
    vecs[9]  = mk(1'b1, 5'd7,  32'h2,        1'b0, 5'd7,  5'd8,  1'b1, 1'b0, 5'd7,  32'h1,      1'b1, 32'h1,      1'b0, 32'h0,      3'd1);
    vecs[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  5'd8,  1'b1, 1'b0, 5'd7,  32'h1,      1'b1, 32'h2,      1'b0, 32'h0,      3'd2);
    vecs[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  1'b1, 1'b0, 5'd7,  32'h1,      1'b0, 32'h0,      1'b1, 32'h2,      3'd2);
    vecs[12] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd8,  1'b1, 1'b1, 5'd7,  32'h1,      1'b1, 32'h2,      1'b0, 32'h0,      3'd2);
    vecs[13] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd8,  1'b1, 1'b1, 5'd7,  32'h2,      1'b1, 32'h2,      1'b0, 32'h0,      3'd1);
    vecs[14] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd8,  1'b1, 1'b0, 5'd0,  32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0);

    tick();
    tick();
    // Reset values, sampled while rst_n is still low.
    check("reset_state",
          {bus.wb_ready, bus.rf_we3, bus.count, bus.lk_hit1, bus.lk_data1},
          {1'b1, 1'b0, 3'd0, 1'b0, 32'h0});
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of operation.
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    #1;
    check("midop_filled", {bus.count, bus.wb_ready, bus.rf_we3, bus.lk_hit1, bus.lk_data1},
          {3'd3, 1'b1, 1'b1, 1'b1, 32'h33});
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.count, bus.wb_ready, bus.rf_we3, bus.lk_hit1, bus.rf_a3},
          {3'd0, 1'b1, 1'b0, 1'b0, 5'd0});
    #1;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    check("after_reset_empty", {bus.count, bus.rf_we3}, {3'd0, 1'b0});

    // Table vectors: ordered drain, $zero drop, youngest-match bypass.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].drain, vecs[i].lk1, vecs[i].lk2);
      #1;
      check($sformatf("vec%0d", i),
            {bus.wb_ready, bus.rf_we3, bus.rf_a3, bus.rf_wd3, bus.lk_hit1, bus.lk_data1,
             bus.lk_hit2, bus.lk_data2, bus.count},
            {vecs[i].e_ready, vecs[i].e_we, vecs[i].e_a3, vecs[i].e_wd, vecs[i].e_hit1,
             vecs[i].e_d1, vecs[i].e_hit2, vecs[i].e_d2, vecs[i].e_cnt});
      tick();
    end

    // Full queue: 5th request held, accepted only after a drain, order kept across wrap.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, AW'(k), 32'h300 + DW'(k), 1'b0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b1, 5'd9, 32'h309, 1'b0, 5'd0, 5'd0);
    #1;
    check("full_count_ready", {bus.count, bus.wb_ready}, {3'd4, 1'b0});
    tick();
    check("full_held", {bus.count, bus.wb_ready}, {3'd4, 1'b0});
    bus.drain_en = 1'b1;
    #1;
    check("full_drain_no_enq", {bus.wb_ready, bus.rf_we3, bus.rf_a3, bus.rf_wd3},
          {1'b0, 1'b1, 5'd1, 32'h301});
    tick();
    bus.drain_en = 1'b0;
    #1;
    check("ready_after_drain", {bus.count, bus.wb_ready}, {3'd3, 1'b1});
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0);
    #1;
    check("fifth_accepted", {bus.count, bus.lk_hit1, bus.lk_data1}, {3'd4, 1'b1, 32'h309});
    begin
      logic [AW-1:0] order [4];
      order[0] = 5'd2; order[1] = 5'd3; order[2] = 5'd4; order[3] = 5'd9;
      for (int k = 0; k < 4; k++) begin
        #1;
        check($sformatf("wrap_order%0d", k), {bus.rf_we3, bus.rf_a3, bus.rf_wd3},
              {1'b1, order[k], 32'h300 + DW'(order[k])});
        tick();
      end
    end
    #1;
    check("wrap_empty", {bus.rf_we3, bus.count}, {1'b0, 3'd0});

    // Continuous stream with drain every cycle: occupancy holds at one.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, AW'(i), 32'h600 + DW'(i), 1'b1, 5'd0, 5'd0);
      #1;
      if (i == 1) begin
        check("stream_first", {bus.count, bus.rf_we3}, {3'd0, 1'b0});
      end else begin
        check($sformatf("stream%0d", i), {bus.count, bus.rf_we3, bus.rf_a3, bus.rf_wd3},
              {3'd1, 1'b1, AW'(i - 1), 32'h600 + DW'(i - 1)});
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    #1;
    check("stream_last", {bus.count, bus.rf_we3, bus.rf_a3, bus.rf_wd3},
          {3'd1, 1'b1, 5'd8, 32'h608});
    tick();
    #1;
    check("stream_done", {bus.count, bus.rf_we3}, {3'd0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
